// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a bank of NUM_REGS negedge-capturing 32-bit registers.
// One edge from request to ack/err; one write per two cycles; losers wait with req held.
module reg_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  parameter int AW       = 3,
  parameter int IDW      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    ack,
  output logic [NUM_REQ-1:0]    err,
  output logic [NUM_REGS-1:0]   reg_cs,
  output logic [31:0]           reg_d,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                state, state_nxt;
  logic [IDW-1:0]        prio, prio_nxt;
  logic [NUM_REQ-1:0]    ack_nxt, err_nxt;
  logic [NUM_REGS-1:0]   cs_nxt;
  logic [31:0]           d_nxt;
  logic [IDW-1:0]        gid_nxt;
  logic                  busy_nxt;

  logic [AW-1:0]         addr_arr [NUM_REQ];
  logic [31:0]           data_arr [NUM_REQ];
  logic [2*NUM_REQ-1:0]  req_rot;
  logic                  win_found;
  logic [IDW-1:0]        win;
  int                    win_sum;
  logic [AW-1:0]         win_addr;
  logic                  addr_ok;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*AW +: AW];
      data_arr[i] = req_data[i*32 +: 32];
    end
  end

  // Rotate the request vector so bit 0 is the current priority holder.
  always_comb begin
    req_rot   = {req, req} >> prio;
    win_found = 1'b0;
    win       = '0;
    win_sum   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_rot[k]) begin
        win_found = 1'b1;
        win_sum   = int'(prio) + k;
        if (win_sum >= NUM_REQ) win_sum = win_sum - NUM_REQ;
        win       = IDW'(win_sum);
      end
    end
  end

  assign win_addr = addr_arr[win];
  assign addr_ok  = int'(win_addr) < NUM_REGS;

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    ack_nxt   = '0;
    err_nxt   = '0;
    cs_nxt    = '0;
    d_nxt     = reg_d;
    gid_nxt   = grant_id;
    busy_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = WRITE;
          busy_nxt  = 1'b1;
          gid_nxt   = win;
          d_nxt     = data_arr[win];
          if (addr_ok) begin
            cs_nxt  = NUM_REGS'(1) << win_addr;
            ack_nxt = NUM_REQ'(1) << win;
          end else begin
            err_nxt = NUM_REQ'(1) << win;
          end
          if (int'(win) == NUM_REQ - 1) prio_nxt = '0;
          else                          prio_nxt = win + 1'b1;
        end
      end
      // No arbitration here, so a req still high on this edge is not served twice.
      WRITE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      prio     <= '0;
      ack      <= '0;
      err      <= '0;
      reg_cs   <= '0;
      reg_d    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      prio     <= prio_nxt;
      ack      <= ack_nxt;
      err      <= err_nxt;
      reg_cs   <= cs_nxt;
      reg_d    <= d_nxt;
      grant_id <= gid_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized and directed bench for reg_write_arbiter against a rule-level reference model.
module tb_reg_write_arbiter;
  localparam int NR  = 4;
  localparam int NG  = 6;
  localparam int AW  = 3;
  localparam int IDW = 2;
  localparam int VW  = 2*NR + NG + 32 + IDW + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*32-1:0]  req_data;
  logic [NR-1:0]     ack, err;
  logic [NG-1:0]     reg_cs;
  logic [31:0]       reg_d;
  logic [IDW-1:0]    grant_id;
  logic              busy;

  reg_write_arbiter #(.NUM_REQ(NR), .NUM_REGS(NG), .AW(AW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .err(err), .reg_cs(reg_cs), .reg_d(reg_d), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state: outputs the spec says should be visible after the last edge.
  logic [NR-1:0]  m_ack, m_err;
  logic [NG-1:0]  m_cs;
  logic [31:0]    m_d;
  logic [IDW-1:0] m_gid;
  logic           m_busy;
  int             m_prio;

  wire [VW-1:0] dut_v = {ack, err, reg_cs, reg_d, grant_id, busy};
  wire [VW-1:0] exp_v = {m_ack, m_err, m_cs, m_d, m_gid, m_busy};

  task automatic set_req(input int i, input int a, input logic [31:0] d);
    req_addr[i*AW +: AW] = a[AW-1:0];
    req_data[i*32 +: 32] = d;
    req[i] = 1'b1;
  endtask

  // Advance one clock; the model applies the spec's rules to the inputs present at the edge.
  task automatic tick();
    int w;
    int a;
    if (!rst) begin
      m_ack = '0; m_err = '0; m_cs = '0; m_d = '0; m_gid = '0; m_busy = 1'b0; m_prio = 0;
    end else if (m_busy) begin
      m_ack = '0; m_err = '0; m_cs = '0; m_busy = 1'b0;
    end else if (req != '0) begin
      w = -1;
      for (int k = 0; k < NR; k++)
        if (w < 0 && req[(m_prio + k) % NR]) w = (m_prio + k) % NR;
      a     = int'(req_addr[w*AW +: AW]);
      m_gid = w[IDW-1:0];
      m_d   = req_data[w*32 +: 32];
      if (a < NG) begin
        m_cs = NG'(1) << a; m_ack = NR'(1) << w; m_err = '0;
      end else begin
        m_cs = '0; m_ack = '0; m_err = NR'(1) << w;
      end
      m_busy = 1'b1;
      m_prio = (w + 1) % NR;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_req(1, 2, 32'h1111_2222);
    set_req(3, 4, 32'h3333_4444);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (dut_v !== '0) begin
        n_bad++; $display("FAIL reset_hold cyc=%0d got=%h want=0", cyc, dut_v);
      end
    end
    rst = 1'b1;
    req = '0;
    tick();
    n_cmp++;
    if (dut_v !== exp_v) begin
      n_bad++; $display("FAIL reset_release cyc=%0d got=%h want=%h", cyc, dut_v, exp_v);
    end
  endtask

  task automatic test_single();
    set_req(2, 5, 32'hDEADBEEF);
    tick();
    n_cmp++;
    if ({reg_cs, reg_d, ack, err, grant_id, busy} !== {6'b10_0000, 32'hDEADBEEF, 4'b0100, 4'b0000, 2'd2, 1'b1}) begin
      n_bad++; $display("FAIL single_write cs=%b d=%h ack=%b gid=%0d busy=%b want cs=100000 d=deadbeef ack=0100 gid=2 busy=1",
                        reg_cs, reg_d, ack, grant_id, busy);
    end
    req[2] = 1'b0;
    tick();
    n_cmp++;
    if ({reg_cs, ack, err, busy} !== '0) begin
      n_bad++; $display("FAIL single_clear cs=%b ack=%b err=%b busy=%b want all 0", reg_cs, ack, err, busy);
    end
    n_cmp++;
    if (dut_v !== exp_v) begin
      n_bad++; $display("FAIL single_model got=%h want=%h", dut_v, exp_v);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int when[$];
    rst = 1'b0; tick(); tick(); rst = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, i, $urandom);
    for (int c = 0; c < 20 && order.size() < NR; c++) begin
      tick();
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL rr_model cyc=%0d got=%h want=%h", cyc, dut_v, exp_v);
      end
      for (int i = 0; i < NR; i++)
        if (ack[i]) begin order.push_back(i); when.push_back(cyc); end
      req = req & ~m_ack;
    end
    n_cmp++;
    if (order.size() != NR) begin
      n_bad++; $display("FAIL rr_count got=%0d acks want=%0d", order.size(), NR);
    end else begin
      for (int i = 0; i < NR; i++) begin
        n_cmp++;
        if (order[i] != i) begin
          n_bad++; $display("FAIL rr_order slot=%0d got=%0d want=%0d", i, order[i], i);
        end
        if (i > 0) begin
          n_cmp++;
          if (when[i] - when[i-1] != 2) begin
            n_bad++; $display("FAIL rr_spacing slot=%0d got=%0d want=2", i, when[i] - when[i-1]);
          end
        end
      end
    end
    tick();
  endtask

  task automatic test_fairness();
    int grants[$];
    set_req(0, 1, $urandom);
    set_req(3, 2, $urandom);
    for (int c = 0; c < 12 && grants.size() < 3; c++) begin
      tick();
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL fair_model cyc=%0d got=%h want=%h", cyc, dut_v, exp_v);
      end
      if ((ack | err) != '0) grants.push_back(int'(grant_id));
      if (m_ack[3]) req[3] = 1'b0;
      if (m_ack[0]) begin
        if (grants.size() >= 3) req[0] = 1'b0;
        else req_data[31:0] = $urandom;
      end
    end
    n_cmp++;
    if (grants.size() != 3 || grants[0] != 0 || grants[1] != 3 || grants[2] != 0) begin
      n_bad++; $display("FAIL fair_seq got=%p want='{0,3,0}", grants);
    end
    req = '0;
    tick();
  endtask

  task automatic test_bad_addr();
    set_req(1, 7, 32'hBAD0_0001);
    tick();
    n_cmp++;
    if ({err, ack, reg_cs, busy} !== {4'b0010, 4'b0000, 6'b0, 1'b1}) begin
      n_bad++; $display("FAIL bad_addr err=%b ack=%b cs=%b busy=%b want err=0010 ack=0 cs=0 busy=1", err, ack, reg_cs, busy);
    end
    req[1] = 1'b0;
    tick();
    n_cmp++;
    if (dut_v !== exp_v) begin
      n_bad++; $display("FAIL bad_addr_clear got=%h want=%h", dut_v, exp_v);
    end
    set_req(1, 2, $urandom);
    set_req(2, 3, $urandom);
    tick();
    n_cmp++;
    if ({grant_id, ack} !== {2'd2, 4'b0100}) begin
      n_bad++; $display("FAIL bad_addr_prio gid=%0d ack=%b want gid=2 ack=0100", grant_id, ack);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    set_req(3, 0, 32'hC0FF_EE00);
    tick();
    n_cmp++;
    if ({ack, grant_id, busy} !== {4'b1000, 2'd3, 1'b1}) begin
      n_bad++; $display("FAIL mid_grant ack=%b gid=%0d busy=%b want ack=1000 gid=3 busy=1", ack, grant_id, busy);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (dut_v !== '0) begin
      n_bad++; $display("FAIL mid_reset got=%h want=0", dut_v);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({ack, grant_id, reg_cs, reg_d} !== {4'b1000, 2'd3, 6'b00_0001, 32'hC0FF_EE00}) begin
      n_bad++; $display("FAIL mid_reserve ack=%b gid=%0d cs=%b d=%h want ack=1000 gid=3 cs=000001 d=c0ffee00",
                        ack, grant_id, reg_cs, reg_d);
    end
    req = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    int t0;
    bit seen;
    seen = 1'b0;
    t0 = 0;
    set_req(0, 4, 32'hAAAA_0001);
    for (int c = 0; c < 6 && !seen; c++) begin
      tick();
      if (ack[0]) begin seen = 1'b1; t0 = cyc; end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL b2b_first got no ack[0] want ack within 6 cycles");
    end
    req_data[31:0] = 32'hAAAA_0002;
    tick();
    n_cmp++;
    if ({busy, reg_cs, ack, err} !== '0) begin
      n_bad++; $display("FAIL b2b_gap busy=%b cs=%b ack=%b err=%b want all 0", busy, reg_cs, ack, err);
    end
    tick();
    n_cmp++;
    if ({ack, reg_d} !== {4'b0001, 32'hAAAA_0002} || cyc - t0 != 2) begin
      n_bad++; $display("FAIL b2b_second ack=%b d=%h gap=%0d want ack=0001 d=aaaa0002 gap=2", ack, reg_d, cyc - t0);
    end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 60) != 0;
      tick();
      n_cmp++;
      if (dut_v !== exp_v) begin
        n_bad++; $display("FAIL rand_model cyc=%0d got=%h want=%h", cyc, dut_v, exp_v);
      end
      n_cmp++;
      if ($countones(reg_cs) > 1 || (!busy && reg_cs != '0)) begin
        n_bad++; $display("FAIL rand_cs cyc=%0d cs=%b busy=%b want onehot0 and zero when idle", cyc, reg_cs, busy);
      end
      for (int i = 0; i < NR; i++) begin
        if (m_ack[i] || m_err[i]) begin
          if ($urandom % 2 == 0) set_req(i, int'($urandom % 8), $urandom);
          else req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom % 4 == 0) set_req(i, int'($urandom % 8), $urandom);
        end else if ($urandom % 32 == 0 && !(m_busy && int'(m_gid) == i)) begin
          req[i] = 1'b0;
        end
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    req_addr = '0;
    req_data = '0;
    m_ack = '0; m_err = '0; m_cs = '0; m_d = '0; m_gid = '0; m_busy = 1'b0; m_prio = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_bad_addr();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
